// File: rtl/ram_wport_queue.sv
// Two-lane, in-order write queue feeding the single write port of the 16-entry register RAM.
// Optional WQ_COALESCE_EN: merges a lane into the youngest pending entry when addresses match.
module ram_wport_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    input  logic [3:0]       in0_addr,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in1_valid,
    input  logic [3:0]       in1_addr,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in_ready,
    output logic             out_wea,
    output logic [3:0]       out_addrw,
    output logic [WIDTH-1:0] out_din,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

    typedef struct packed {
        logic [3:0]       addr;
        logic [WIDTH-1:0] data;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] head, tail, slot1;
    logic [CW-1:0] count_next;
    logic          pop, acc0, acc1, p0, p1;

    // Ready looks only at the registered count so producers never see a valid->ready loop.
    assign in_ready = (count <= READY_MAX);
    assign pop      = (count != '0);
    assign acc0     = in0_valid & in_ready;
    assign acc1     = in1_valid & in_ready;

`ifdef WQ_COALESCE_EN
    logic [PW-1:0] last_ptr;
    logic          can_merge, drop0, m0, m1;

    assign last_ptr  = tail - PW'(1);
    // With a single entry, tail-1 is the head leaving this cycle, so it cannot absorb a merge.
    assign can_merge = (count >= CW'(2));
    assign drop0     = acc0 & acc1 & (in0_addr == in1_addr);
    assign m0        = acc0 & ~drop0 & can_merge & (mem[last_ptr].addr == in0_addr);
    assign p0        = acc0 & ~drop0 & ~m0;
    assign m1        = acc1 & ~p0 & can_merge & (mem[last_ptr].addr == in1_addr);
    assign p1        = acc1 & ~m1;
`else
    assign p0 = acc0;
    assign p1 = acc1;
`endif

    assign slot1      = p0 ? tail + PW'(1) : tail;
    assign count_next = count + CW'(p0) + CW'(p1) - CW'(pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (pop) head <= head + PW'(1);
            tail  <= tail + PW'(p0) + PW'(p1);
            count <= count_next;
        end
    end

    // Storage is deliberately not reset; pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (p0) mem[tail]  <= '{addr: in0_addr, data: in0_data};
        if (p1) mem[slot1] <= '{addr: in1_addr, data: in1_data};
`ifdef WQ_COALESCE_EN
        if (m0) mem[last_ptr].data <= in0_data;
        if (m1) mem[last_ptr].data <= in1_data;
`endif
    end

    always_comb begin
        out_wea   = pop;
        out_addrw = '0;
        out_din   = '0;
        if (pop) begin
            out_addrw = mem[head].addr;
            out_din   = mem[head].data;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && acc1)
            assert (int'(count) + int'(p0) + int'(p1) <= DEPTH + int'(pop));
    end
`endif

endmodule

// File: tb/tb_ram_wport_queue.sv
// Directed bench for ram_wport_queue: reset, single/dual push, backpressure, wrap, reset mid-drain.
module tb_ram_wport_queue;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in0_valid, in1_valid;
    logic [3:0]       in0_addr, in1_addr;
    logic [WIDTH-1:0] in0_data, in1_data;
    logic             in_ready, out_wea;
    logic [3:0]       out_addrw;
    logic [WIDTH-1:0] out_din;
    logic [CW-1:0]    count;

    int n_chk = 0;
    int n_pass = 0;
    logic [35:0] wlog [$];
    logic [35:0] mdl  [$];

    ram_wport_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in0_valid(in0_valid), .in0_addr(in0_addr), .in0_data(in0_data),
        .in1_valid(in1_valid), .in1_addr(in1_addr), .in1_data(in1_data),
        .in_ready(in_ready), .out_wea(out_wea), .out_addrw(out_addrw),
        .out_din(out_din), .count(count)
    );

    always #5 clk = ~clk;

    // Every RAM write commits on the edge following a cycle with out_wea high.
    always @(negedge clk) if (out_wea) wlog.push_back({out_addrw, out_din});

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [3:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [3:0] a1, input logic [31:0] d1);
        in0_valid = v0; in0_addr = a0; in0_data = d0;
        in1_valid = v1; in1_addr = a1; in1_data = d1;
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    endtask

    initial begin
        int          nxt, seq;
        logic        rdy, v0, v1;
        logic [1:0]  r;
        logic [3:0]  a0, a1;
        logic [31:0] d0, d1;

        idle();
        // reset and idle
        step();
        chk("rst_ready", in_ready, 1);
        chk("rst_wea", out_wea, 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("idle_cnt%0d", i), count, 0);
            chk($sformatf("idle_rdy%0d", i), in_ready, 1);
            chk($sformatf("idle_wea%0d", i), out_wea, 0);
            chk($sformatf("idle_addr%0d", i), out_addrw, 0);
            chk($sformatf("idle_din%0d", i), out_din, 0);
        end

        // single push
        drive(1'b1, 4'd3, 32'hA5A5_0001, 1'b0, 4'd0, 32'd0);
        step();
        idle();
        chk("single_wea", out_wea, 1);
        chk("single_addr", out_addrw, 3);
        chk("single_din", out_din, 32'hA5A5_0001);
        chk("single_cnt1", count, 1);
        step();
        chk("single_wea_off", out_wea, 0);
        chk("single_cnt0", count, 0);

        // dual push, same address
        drive(1'b1, 4'd5, 32'h11, 1'b1, 4'd5, 32'h22);
        step();
        idle();
`ifdef WQ_COALESCE_EN
        chk("dual_cnt", count, 1);
        chk("dual_addr", out_addrw, 5);
        chk("dual_din", out_din, 32'h22);
        step();
        chk("dual_wea_off", out_wea, 0);
`else
        chk("dual_cnt", count, 2);
        chk("dual_addr0", out_addrw, 5);
        chk("dual_din0", out_din, 32'h11);
        step();
        chk("dual_addr1", out_addrw, 5);
        chk("dual_din1", out_din, 32'h22);
        step();
        chk("dual_wea_off", out_wea, 0);
`endif
        chk("dual_cnt0", count, 0);

        // backpressure: producer holds each pair until accepted
        wlog.delete();
        nxt = 0;
        for (int c = 0; c < 30 && (nxt < 6 || count != 0); c++) begin
            rdy = in_ready;
            if (nxt < 6) drive(1'b1, 4'(nxt), 32'h100 + nxt, 1'b1, 4'(nxt + 1), 32'h101 + nxt);
            else idle();
            step();
            if (nxt < 6) begin
                if (rdy) begin
                    nxt += 2;
                    if (nxt == 4) begin
                        chk("bp_cnt3", count, 3);
                        chk("bp_rdy0", in_ready, 0);
                    end
                end else begin
                    chk("bp_ignore", count, 2);
                end
            end
        end
        idle();
        chk("bp_sent", nxt, 6);
        chk("bp_drain", count, 0);
        chk("bp_len", wlog.size(), 6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("bp_w%0d", i), (i < wlog.size()) ? wlog[i] : 36'hx,
                {4'(i), 32'h100 + i});

        // random single/dual pushes across pointer wrap; sequential addresses never collide
        wlog.delete();
        mdl.delete();
        seq = 0;
        for (int c = 0; c < 20; c++) begin
            r  = 2'($urandom_range(1, 3));
            v0 = r[0];
            v1 = r[1];
            d0 = $urandom;
            d1 = $urandom;
            if (in_ready) begin
                a0 = 4'(seq);
                if (v0) begin mdl.push_back({a0, d0}); seq++; end
                a1 = 4'(seq);
                if (v1) begin mdl.push_back({a1, d1}); seq++; end
            end else begin
                a0 = 4'(seq);
                a1 = 4'(seq + 1);
            end
            drive(v0, a0, d0, v1, a1, d1);
            step();
        end
        idle();
        for (int c = 0; c < 20 && count != 0; c++) step();
        chk("rnd_drain", count, 0);
        chk("rnd_len", wlog.size(), mdl.size());
        for (int i = 0; i < mdl.size(); i++)
            chk($sformatf("rnd_w%0d", i), (i < wlog.size()) ? wlog[i] : 36'hx, mdl[i]);

        // reset with three entries pending
        drive(1'b1, 4'd8, 32'h8, 1'b1, 4'd9, 32'h9);
        step();
        drive(1'b1, 4'd10, 32'hA, 1'b1, 4'd11, 32'hB);
        step();
        idle();
        chk("rmid_cnt3", count, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rmid_wea", out_wea, 0);
        chk("rmid_cnt", count, 0);
        chk("rmid_rdy", in_ready, 1);
        chk("rmid_addr", out_addrw, 0);
        wlog.delete();
        drive(1'b1, 4'd7, 32'hFF, 1'b0, 4'd0, 32'd0);
        step();
        idle();
        chk("post_wea", out_wea, 1);
        chk("post_addr", out_addrw, 7);
        chk("post_din", out_din, 32'hFF);
        step();
        chk("post_cnt", count, 0);
        chk("post_len", wlog.size(), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
